// File: rtl/trace_pkg.sv
// Shared types and constants for the execution-trace capture path.
package trace_pkg;

    localparam int PC_W_DEF   = 8;
    localparam int DATA_W_DEF = 32;

    localparam logic [7:0] DROP_MAX = 8'd255;

    typedef enum logic [1:0] {
        TR_IDLE,
        TR_ARMED,
        TR_RUN
    } tr_state_t;

    typedef struct packed {
        logic [PC_W_DEF-1:0]   pc;
        logic [DATA_W_DEF-1:0] result;
    } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with show-ahead head, synchronous flush and occupancy count.
module trace_fifo #(
    parameter  int DEPTH = 16,
    parameter  int W     = 40,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= din;
    end

    assign dout  = empty ? '0 : mem[rptr];
    assign count = cnt;

endmodule

// File: rtl/exec_trace_buffer.sv
// Execution-trace receiver: samples pc/result at retire boundaries into a drainable FIFO.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   TR_IDLE  | capture off; waits for capture_en
//   TR_ARMED | next edge stores the current pc/result unconditionally
//   TR_RUN   | stores a record whenever core_pc differs from last_pc
module exec_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 8,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     capture_en,
    input  logic                     clear,
    input  logic [PC_W-1:0]          core_pc,
    input  logic [DATA_W-1:0]        core_result,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [PC_W-1:0]          rd_pc,
    output logic [DATA_W-1:0]        rd_result,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    tr_state_t         state;
    logic [PC_W-1:0]   last_pc;
    logic              sample;
    logic              want_push;
    logic              do_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop;

    assign sample    = capture_en && ((state == TR_ARMED) || (state == TR_RUN));
    assign want_push = sample && ((state == TR_ARMED) || (core_pc != last_pc));
    assign rd_valid  = !fifo_empty;
    assign do_pop    = rd_valid && rd_ready;
    assign drop      = want_push && fifo_full && !do_pop;

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (PC_W + DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (clear),
        .push    (want_push),
        .pop     (do_pop),
        .din     ({core_pc, core_result}),
        .dout    ({rd_pc, rd_result}),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= TR_IDLE;
            last_pc  <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (sample) last_pc <= core_pc;
            if (clear) begin
                state    <= capture_en ? TR_ARMED : TR_IDLE;
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else begin
                case (state)
                    TR_IDLE:  state <= capture_en ? TR_ARMED : TR_IDLE;
                    TR_ARMED: state <= capture_en ? TR_RUN : TR_IDLE;
                    TR_RUN:   state <= capture_en ? TR_RUN : TR_IDLE;
                    default:  state <= TR_IDLE;
                endcase
                if (drop) begin
                    overflow <= 1'b1;
                    if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Randomised and directed checks of exec_trace_buffer against a queue-based trace model.
module tb_exec_trace_buffer;

    localparam int DEPTH  = 16;
    localparam int PC_W   = 8;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              capture_en;
    logic              clear;
    logic [PC_W-1:0]   core_pc;
    logic [DATA_W-1:0] core_result;
    logic              rd_valid;
    logic              rd_ready;
    logic [PC_W-1:0]   rd_pc;
    logic [DATA_W-1:0] rd_result;
    logic [4:0]        count;
    logic              overflow;
    logic [7:0]        drop_cnt;

    exec_trace_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .capture_en  (capture_en),
        .clear       (clear),
        .core_pc     (core_pc),
        .core_result (core_result),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_pc       (rd_pc),
        .rd_result   (rd_result),
        .count       (count),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] res;
    } rec_t;

    rec_t            q[$];
    bit              m_capturing;
    bit              m_first_pending;
    logic [PC_W-1:0] m_last;
    bit              m_ovf;
    int              m_drops;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_capturing     = 0;
        m_first_pending = 0;
        m_last          = '0;
        m_ovf           = 0;
        m_drops         = 0;
    endtask

    // One rising edge of the trace rules, using the inputs as they stand before the edge.
    task automatic model_step();
        bit take;
        bit pop;
        bit was_active;
        if (clear) begin
            q.delete();
            m_ovf           = 0;
            m_drops         = 0;
            m_capturing     = capture_en;
            m_first_pending = capture_en;
            return;
        end
        pop        = (q.size() != 0) && rd_ready;
        was_active = m_capturing && !m_first_pending;
        take       = 0;
        if (!capture_en) begin
            m_capturing     = 0;
            m_first_pending = 0;
        end else if (!m_capturing) begin
            m_capturing     = 1;
            m_first_pending = 1;
        end else begin
            take            = m_first_pending || (core_pc != m_last);
            m_first_pending = 0;
            m_last          = core_pc;
        end
        if (was_active && !capture_en) take = 0;
        if (pop) void'(q.pop_front());
        if (take) begin
            if (q.size() < DEPTH) q.push_back('{core_pc, core_result});
            else begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
        end
    endtask

    task automatic compare_all();
        chk("rd_valid",  64'(rd_valid),  64'(q.size() != 0));
        chk("rd_pc",     64'(rd_pc),     (q.size() != 0) ? 64'(q[0].pc)  : 64'd0);
        chk("rd_result", 64'(rd_result), (q.size() != 0) ? 64'(q[0].res) : 64'd0);
        chk("count",     64'(count),     64'(q.size()));
        chk("overflow",  64'(overflow),  64'(m_ovf));
        chk("drop_cnt",  64'(drop_cnt),  64'(m_drops));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        reset_n     = 1'b0;
        capture_en  = 1'b0;
        clear       = 1'b0;
        core_pc     = '0;
        core_result = '0;
        rd_ready    = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("rst_count", 64'(count), 0);
        chk("rst_valid", 64'(rd_valid), 0);
        chk("rst_ovf",   64'(overflow), 0);

        // In-order capture of four distinct PCs
        capture_en = 1'b1;
        cycle();
        for (int p = 0; p < 4; p++) begin
            core_pc = 8'(p); core_result = 32'(10 * p);
            cycle();
        end
        chk("t1_count", 64'(count), 4);
        capture_en = 1'b0;
        cycle();
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t1_pc",  64'(rd_pc), 64'(i));
            chk("t1_res", 64'(rd_result), 64'(10 * i));
            cycle();
        end
        rd_ready = 1'b0;
        chk("t1_empty", 64'(count), 0);

        // Held PC stores one record
        capture_en = 1'b1; core_pc = 8'd5; core_result = 32'd55;
        cycle();
        repeat (6) cycle();
        chk("t2_count", 64'(count), 1);
        chk("t2_pc",    64'(rd_pc), 5);
        capture_en = 1'b0; rd_ready = 1'b1;
        cycle();
        rd_ready = 1'b0;
        chk("t2_empty", 64'(count), 0);

        // Overflow with 20 distinct PCs
        clear = 1'b1; capture_en = 1'b1;
        cycle();
        clear = 1'b0;
        for (int p = 0; p < 20; p++) begin
            core_pc = 8'(p); core_result = 32'(p * 3);
            cycle();
        end
        capture_en = 1'b0;
        cycle();
        chk("t3_count", 64'(count), 16);
        chk("t3_ovf",   64'(overflow), 1);
        chk("t3_drop",  64'(drop_cnt), 4);
        rd_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("t3_pc", 64'(rd_pc), 64'(i));
            cycle();
        end
        rd_ready = 1'b0;
        chk("t3_left", 64'(count), 7);

        // Clear, then first sample (same PC as last) taken via ARMED
        clear = 1'b1; capture_en = 1'b1; core_pc = 8'd19;
        cycle();
        clear = 1'b0;
        chk("t5_count", 64'(count), 0);
        chk("t5_valid", 64'(rd_valid), 0);
        chk("t5_ovf",   64'(overflow), 0);
        chk("t5_drop",  64'(drop_cnt), 0);
        cycle();
        chk("t5_armed", 64'(count), 1);
        chk("t5_pc",    64'(rd_pc), 19);
        cycle();
        chk("t5_hold",  64'(count), 1);

        // Full FIFO: push with simultaneous pop is not a drop
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        for (int p = 0; p < 16; p++) begin
            core_pc = 8'(100 + p); core_result = 32'(p);
            cycle();
        end
        chk("t4_full", 64'(count), 16);
        core_pc = 8'd116; rd_ready = 1'b1;
        cycle();
        chk("t4_count", 64'(count), 16);
        chk("t4_ovf",   64'(overflow), 0);
        chk("t4_drop",  64'(drop_cnt), 0);
        chk("t4_head",  64'(rd_pc), 101);

        // Reset mid-drain
        capture_en = 1'b0;
        repeat (7) cycle();
        chk("t6_count", 64'(count), 9);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_count0", 64'(count), 0);
        chk("t6_valid0", 64'(rd_valid), 0);
        chk("t6_pc0",    64'(rd_pc), 0);
        chk("t6_res0",   64'(rd_result), 0);
        chk("t6_ovf0",   64'(overflow), 0);
        chk("t6_drop0",  64'(drop_cnt), 0);
        model_reset();
        @(negedge clk);
        reset_n  = 1'b1;
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            core_pc = 8'($urandom_range(0, 255));
            cycle();
        end
        chk("t6_idle", 64'(count), 0);
        capture_en = 1'b1; core_pc = 8'd7;
        cycle();
        chk("t6_arm", 64'(count), 0);
        cycle();
        chk("t6_cap", 64'(count), 1);

        // Randomised traffic, including a long stall to saturate drop_cnt
        for (int i = 0; i < 3000; i++) begin
            capture_en  = ($urandom_range(0, 19) != 0);
            core_pc     = 8'($urandom_range(0, 3));
            core_result = $urandom;
            if (i >= 1000 && i < 1500) begin
                clear    = 1'b0;
                rd_ready = 1'b0;
            end else begin
                clear    = ($urandom_range(0, 199) == 0);
                rd_ready = (i < 1000) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) != 0);
            end
            cycle();
            if (i == 1499) chk("sat_drop", 64'(drop_cnt), 255);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
